// File: rtl/lpe_array_tile_sequencer_if.sv
// Stream bundle around the tile sequencer: command, operand inputs, array edge lanes,
// bottom-row psum monitor taps and status flags.
interface lpe_array_tile_sequencer_if #(
  parameter int unsigned PE_NUMBER_I = 4,
  parameter int unsigned PE_NUMBER_J = 4,
  parameter int unsigned OP0_WIDTH   = 16,
  parameter int unsigned OP1_WIDTH   = 16,
  parameter int unsigned K_WIDTH     = 16
);
  logic [K_WIDTH-1:0]               s_axis_cmd_tdata;
  logic                             s_axis_cmd_tvalid;
  logic                             s_axis_cmd_tready;
  logic [PE_NUMBER_J*OP0_WIDTH-1:0] s_axis_a_tdata;
  logic                             s_axis_a_tvalid;
  logic                             s_axis_a_tready;
  logic [PE_NUMBER_I*OP1_WIDTH-1:0] s_axis_w_tdata;
  logic                             s_axis_w_tvalid;
  logic                             s_axis_w_tready;
  logic [PE_NUMBER_J*OP0_WIDTH-1:0] m_axis_l_tdata;
  logic [PE_NUMBER_J-1:0]           m_axis_l_tvalid;
  logic [PE_NUMBER_J-1:0]           m_axis_l_tready;
  logic [PE_NUMBER_J-1:0]           m_axis_l_tlast;
  logic [PE_NUMBER_I*OP1_WIDTH-1:0] m_axis_t_tdata;
  logic [PE_NUMBER_I-1:0]           m_axis_t_tvalid;
  logic [PE_NUMBER_I-1:0]           m_axis_t_tready;
  logic [PE_NUMBER_I-1:0]           m_axis_t_tlast;
  logic [PE_NUMBER_I-1:0]           mon_d_tvalid;
  logic [PE_NUMBER_I-1:0]           mon_d_tready;
  logic [PE_NUMBER_I-1:0]           mon_d_tlast;
  logic                             busy;
  logic                             done;
  logic                             err_cmd_zero;

  // Sequencer side.
  modport slave (
    input  s_axis_cmd_tdata, s_axis_cmd_tvalid,
    output s_axis_cmd_tready,
    input  s_axis_a_tdata, s_axis_a_tvalid,
    output s_axis_a_tready,
    input  s_axis_w_tdata, s_axis_w_tvalid,
    output s_axis_w_tready,
    output m_axis_l_tdata, m_axis_l_tvalid, m_axis_l_tlast,
    input  m_axis_l_tready,
    output m_axis_t_tdata, m_axis_t_tvalid, m_axis_t_tlast,
    input  m_axis_t_tready,
    input  mon_d_tvalid, mon_d_tready, mon_d_tlast,
    output busy, done, err_cmd_zero
  );

  // Environment side (command source, operand sources, array).
  modport master (
    output s_axis_cmd_tdata, s_axis_cmd_tvalid,
    input  s_axis_cmd_tready,
    output s_axis_a_tdata, s_axis_a_tvalid,
    input  s_axis_a_tready,
    output s_axis_w_tdata, s_axis_w_tvalid,
    input  s_axis_w_tready,
    input  m_axis_l_tdata, m_axis_l_tvalid, m_axis_l_tlast,
    output m_axis_l_tready,
    input  m_axis_t_tdata, m_axis_t_tvalid, m_axis_t_tlast,
    output m_axis_t_tready,
    output mon_d_tvalid, mon_d_tready, mon_d_tlast,
    input  busy, done, err_cmd_zero
  );
endinterface

// File: rtl/lpe_array_tile_sequencer.sv
// Per-tile sequencer for a systolic LPE array: forks operand beats onto the edge lanes,
// tags the last beat, and waits for every bottom-row psum tlast before pulsing done.
module lpe_array_tile_sequencer #(
  parameter int unsigned PE_NUMBER_I = 4,
  parameter int unsigned PE_NUMBER_J = 4,
  parameter int unsigned OP0_WIDTH   = 16,
  parameter int unsigned OP1_WIDTH   = 16,
  parameter int unsigned K_WIDTH     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  lpe_array_tile_sequencer_if.slave   bus_io
);

  typedef enum logic [1:0] {StIdle, StFeed, StDrain} state_e;

  state_e                   state_q;
  logic [K_WIDTH-1:0]       k_q, a_cnt_q, w_cnt_q;
  logic [PE_NUMBER_J-1:0]   sent_l_q;
  logic [PE_NUMBER_I-1:0]   sent_t_q, d_seen_q;
  logic                     done_q, err_q;

  logic                             feed, a_more, w_more, a_fire, w_fire, cmd_fire;
  logic [K_WIDTH-1:0]               k_last;
  logic [PE_NUMBER_J-1:0]           l_valid, l_take;
  logic [PE_NUMBER_I-1:0]           t_valid, t_take, d_seen_nx;
  logic [PE_NUMBER_J*OP0_WIDTH-1:0] l_data;
  logic [PE_NUMBER_I*OP1_WIDTH-1:0] t_data;

  always_comb begin
    feed     = (state_q == StFeed);
    a_more   = feed & (a_cnt_q < k_q);
    w_more   = feed & (w_cnt_q < k_q);
    k_last   = k_q - K_WIDTH'(1);
    l_data   = bus_io.s_axis_a_tdata;
    t_data   = bus_io.s_axis_w_tdata;
    // A lane that already took the current beat is masked until the beat retires upstream.
    l_valid  = {PE_NUMBER_J{bus_io.s_axis_a_tvalid & a_more}} & ~sent_l_q;
    t_valid  = {PE_NUMBER_I{bus_io.s_axis_w_tvalid & w_more}} & ~sent_t_q;
    l_take   = l_valid & bus_io.m_axis_l_tready;
    t_take   = t_valid & bus_io.m_axis_t_tready;

    bus_io.m_axis_l_tdata  = l_data;
    bus_io.m_axis_l_tvalid = l_valid;
    bus_io.m_axis_l_tlast  = {PE_NUMBER_J{feed & (a_cnt_q == k_last)}};
    bus_io.m_axis_t_tdata  = t_data;
    bus_io.m_axis_t_tvalid = t_valid;
    bus_io.m_axis_t_tlast  = {PE_NUMBER_I{feed & (w_cnt_q == k_last)}};

    bus_io.s_axis_a_tready = a_more & (&(sent_l_q | bus_io.m_axis_l_tready));
    bus_io.s_axis_w_tready = w_more & (&(sent_t_q | bus_io.m_axis_t_tready));
    a_fire   = bus_io.s_axis_a_tvalid & bus_io.s_axis_a_tready;
    w_fire   = bus_io.s_axis_w_tvalid & bus_io.s_axis_w_tready;

    bus_io.s_axis_cmd_tready = (state_q == StIdle);
    cmd_fire = bus_io.s_axis_cmd_tvalid & (state_q == StIdle);

    d_seen_nx = d_seen_q | (bus_io.mon_d_tvalid & bus_io.mon_d_tready & bus_io.mon_d_tlast);

    bus_io.busy         = (state_q != StIdle);
    bus_io.done         = done_q;
    bus_io.err_cmd_zero = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      k_q      <= '0;
      a_cnt_q  <= '0;
      w_cnt_q  <= '0;
      sent_l_q <= '0;
      sent_t_q <= '0;
      d_seen_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_fire) begin
            if (bus_io.s_axis_cmd_tdata != '0) begin
              k_q      <= bus_io.s_axis_cmd_tdata;
              a_cnt_q  <= '0;
              w_cnt_q  <= '0;
              sent_l_q <= '0;
              sent_t_q <= '0;
              d_seen_q <= '0;
              state_q  <= StFeed;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StFeed: begin
          if (a_fire) begin
            a_cnt_q  <= a_cnt_q + K_WIDTH'(1);
            sent_l_q <= '0;
          end else begin
            sent_l_q <= sent_l_q | l_take;
          end
          if (w_fire) begin
            w_cnt_q  <= w_cnt_q + K_WIDTH'(1);
            sent_t_q <= '0;
          end else begin
            sent_t_q <= sent_t_q | t_take;
          end
          d_seen_q <= d_seen_nx;
          if ((a_cnt_q == k_q) && (w_cnt_q == k_q)) state_q <= StDrain;
        end
        StDrain: begin
          d_seen_q <= d_seen_nx;
          if (&d_seen_nx) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lpe_array_tile_sequencer.sv
// Randomized scoreboard bench: tiles are queued as whole operand matrices, a monitor checks
// lane beats, tlast, handshake gating and status pulses against a tile-level model.
module tb_lpe_array_tile_sequencer;
  localparam int unsigned PI = 3;
  localparam int unsigned PJ = 2;
  localparam int unsigned W0 = 16;
  localparam int unsigned W1 = 16;
  localparam int unsigned KW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lpe_array_tile_sequencer_if #(
    .PE_NUMBER_I(PI), .PE_NUMBER_J(PJ), .OP0_WIDTH(W0), .OP1_WIDTH(W1), .K_WIDTH(KW)
  ) bus ();

  lpe_array_tile_sequencer #(
    .PE_NUMBER_I(PI), .PE_NUMBER_J(PJ), .OP0_WIDTH(W0), .OP1_WIDTH(W1), .K_WIDTH(KW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  // Stimulus queues (heads are presented upstream) and expected per-lane beats {last, data}.
  logic [KW-1:0]      cmd_q[$];
  logic [PJ*W0-1:0]   a_src[$];
  logic [PI*W1-1:0]   w_src[$];
  logic [W0:0]        exp_l[PJ][$];
  logic [W1:0]        exp_t[PI][$];

  int n_vec = 0;
  int n_err = 0;
  bit a_fired, w_fired, cmd_fired;

  // Tile-level model state.
  bit              m_busy;
  int unsigned     m_a_left, m_w_left;
  int unsigned     m_l_left[PJ];
  int unsigned     m_t_left[PI];
  logic [PI-1:0]   m_seen;
  longint          m_feed_cyc, m_done_cyc = -1, m_err_cyc = -1;
  longint          cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got timeout expected progress (cycle %0d)", name, cyc);
  endtask

  task automatic push_tile(input int unsigned k);
    logic [PJ*W0-1:0] av;
    logic [PI*W1-1:0] wv;
    cmd_q.push_back(KW'(k));
    for (int unsigned b = 0; b < k; b++) begin
      for (int j = 0; j < PJ; j++) av[j*W0 +: W0] = W0'($urandom);
      for (int i = 0; i < PI; i++) wv[i*W1 +: W1] = W1'($urandom);
      a_src.push_back(av);
      w_src.push_back(wv);
      for (int j = 0; j < PJ; j++) exp_l[j].push_back({b == k - 1, av[j*W0 +: W0]});
      for (int i = 0; i < PI; i++) exp_t[i].push_back({b == k - 1, wv[i*W1 +: W1]});
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((cmd_q.size() != 0 || m_busy) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) fail_now("wait_idle");
    repeat (3) @(posedge clk);
  endtask

  // Driver: retire fired heads, then present fresh randomized handshakes.
  initial begin
    bus.s_axis_cmd_tdata = '0; bus.s_axis_cmd_tvalid = 1'b0;
    bus.s_axis_a_tdata = '0;   bus.s_axis_a_tvalid = 1'b0;
    bus.s_axis_w_tdata = '0;   bus.s_axis_w_tvalid = 1'b0;
    bus.m_axis_l_tready = '0;  bus.m_axis_t_tready = '0;
    bus.mon_d_tvalid = '0; bus.mon_d_tready = '0; bus.mon_d_tlast = '0;
    forever begin
      @(posedge clk);
      #1;
      if (cmd_fired && cmd_q.size() > 0) void'(cmd_q.pop_front());
      if (a_fired && a_src.size() > 0) void'(a_src.pop_front());
      if (w_fired && w_src.size() > 0) void'(w_src.pop_front());
      cmd_fired = 0; a_fired = 0; w_fired = 0;
      bus.s_axis_cmd_tvalid = (cmd_q.size() > 0) && ($urandom_range(3) != 0);
      bus.s_axis_cmd_tdata  = (cmd_q.size() > 0) ? cmd_q[0] : KW'($urandom);
      bus.s_axis_a_tvalid   = (a_src.size() > 0) && ($urandom_range(3) != 0);
      bus.s_axis_a_tdata    = (a_src.size() > 0) ? a_src[0] : (PJ*W0)'($urandom);
      bus.s_axis_w_tvalid   = (w_src.size() > 0) && ($urandom_range(3) != 0);
      bus.s_axis_w_tdata    = (w_src.size() > 0) ? w_src[0] : (PI*W1)'({$urandom, $urandom});
      bus.m_axis_l_tready   = PJ'($urandom | $urandom);
      bus.m_axis_t_tready   = PI'($urandom | $urandom);
      bus.mon_d_tvalid      = PI'($urandom);
      bus.mon_d_tready      = PI'($urandom);
      bus.mon_d_tlast       = PI'($urandom);
    end
  end

  // Monitor and reference model, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        m_busy = 0; m_seen = '0; m_feed_cyc = -1;
      end else begin
        chk("status{busy,done,err,cmd_rdy}",
            {bus.busy, bus.done, bus.err_cmd_zero, bus.s_axis_cmd_tready},
            {m_busy, m_done_cyc == cyc, m_err_cyc == cyc, !m_busy});
        if (!m_busy)
          chk("idle_quiet", {|bus.m_axis_l_tvalid, |bus.m_axis_t_tvalid,
                             bus.s_axis_a_tready, bus.s_axis_w_tready}, '0);
        for (int j = 0; j < PJ; j++) begin
          if (bus.m_axis_l_tvalid[j] && bus.m_axis_l_tready[j]) begin
            if (exp_l[j].size() == 0) chk("l_extra_beat", 1, 0);
            else chk($sformatf("l_lane%0d{last,data}", j),
                     {bus.m_axis_l_tlast[j], bus.m_axis_l_tdata[j*W0 +: W0]},
                     exp_l[j].pop_front());
            if (m_l_left[j] > 0) m_l_left[j]--;
          end
        end
        for (int i = 0; i < PI; i++) begin
          if (bus.m_axis_t_tvalid[i] && bus.m_axis_t_tready[i]) begin
            if (exp_t[i].size() == 0) chk("t_extra_beat", 1, 0);
            else chk($sformatf("t_lane%0d{last,data}", i),
                     {bus.m_axis_t_tlast[i], bus.m_axis_t_tdata[i*W1 +: W1]},
                     exp_t[i].pop_front());
            if (m_t_left[i] > 0) m_t_left[i]--;
          end
        end
        if (bus.s_axis_a_tvalid && bus.s_axis_a_tready) a_fired = 1;
        if (bus.s_axis_w_tvalid && bus.s_axis_w_tready) w_fired = 1;
        if (bus.s_axis_cmd_tvalid && bus.s_axis_cmd_tready) cmd_fired = 1;

        if (m_busy) begin
          m_seen |= bus.mon_d_tvalid & bus.mon_d_tready & bus.mon_d_tlast;
          if (a_fired) begin
            chk("a_beat_within_k", m_a_left != 0, 1);
            if (m_a_left > 0) m_a_left--;
          end
          if (w_fired) begin
            chk("w_beat_within_k", m_w_left != 0, 1);
            if (m_w_left > 0) m_w_left--;
          end
          if (m_a_left == 0 && m_w_left == 0 && m_feed_cyc < 0) m_feed_cyc = cyc;
          if (m_feed_cyc >= 0 && cyc >= m_feed_cyc + 2 && &m_seen) begin
            m_busy = 0;
            m_done_cyc = cyc + 1;
            for (int j = 0; j < PJ; j++) chk("l_beats_per_tile", m_l_left[j], 0);
            for (int i = 0; i < PI; i++) chk("t_beats_per_tile", m_t_left[i], 0);
          end
        end else if (cmd_fired) begin
          if (bus.s_axis_cmd_tdata == '0) begin
            m_err_cyc = cyc + 1;
          end else begin
            m_busy = 1;
            m_a_left = bus.s_axis_cmd_tdata;
            m_w_left = bus.s_axis_cmd_tdata;
            for (int j = 0; j < PJ; j++) m_l_left[j] = bus.s_axis_cmd_tdata;
            for (int i = 0; i < PI; i++) m_t_left[i] = bus.s_axis_cmd_tdata;
            m_seen = '0;
            m_feed_cyc = -1;
          end
        end
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_outputs", {bus.busy, bus.done, bus.err_cmd_zero, |bus.m_axis_l_tvalid,
                          |bus.m_axis_t_tvalid, bus.s_axis_cmd_tready}, 6'b000001);
    rst_n = 1'b1;

    push_tile(3);
    push_tile(0);
    push_tile(2);
    for (int t = 0; t < 40; t++) begin
      n = 0;
      while (cmd_q.size() > 1 && n < 2000) begin
        @(posedge clk);
        n++;
      end
      if (n >= 2000) fail_now("throttle");
      push_tile(($urandom_range(7) == 0) ? 0 : $urandom_range(6, 1));
    end
    push_tile(20);
    push_tile(0);
    wait_idle(5000);

    // Abort a K=5 tile after its first upstream beat.
    push_tile(5);
    n = 0;
    while (!(m_busy && m_a_left < 5) && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 2000) fail_now("mid_tile_start");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    cmd_q.delete(); a_src.delete(); w_src.delete();
    for (int j = 0; j < PJ; j++) exp_l[j].delete();
    for (int i = 0; i < PI; i++) exp_t[i].delete();
    #1;
    chk("mid_tile_reset", {bus.busy, |bus.m_axis_l_tvalid, |bus.m_axis_t_tvalid,
                           bus.s_axis_a_tready, bus.s_axis_w_tready, bus.done}, '0);
    repeat (2) @(posedge clk);
    #2;
    a_fired = 0; w_fired = 0; cmd_fired = 0;
    rst_n = 1'b1;
    push_tile(2);
    wait_idle(2000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
